// File: rtl/sat_add_arbiter.sv
// sat_add_arbiter: one shared W-bit signed saturating adder serving N_REQ
// requesters through a round-robin arbiter, with a one-entry valid/ready
// output register tagged with requester id and saturation flag.
// Optional feature macro: SAT_ADD_ARB_STICKY_EN (per-requester sticky
// saturation flags with sat_clr / sat_sticky ports).
module sat_add_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 4,
  localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_sum,
  output logic [IW-1:0]      out_id,
  output logic               out_sat
`ifdef SAT_ADD_ARB_STICKY_EN
  ,
  input  logic [N_REQ-1:0]   sat_clr,
  output logic [N_REQ-1:0]   sat_sticky
`endif
);

  logic [IW-1:0]    r_ptr;
  logic             r_valid;
  logic [W-1:0]     r_sum;
  logic [IW-1:0]    r_id;
  logic             r_sat;

  logic             w_any;
  logic [IW-1:0]    w_gid;
  logic [N_REQ-1:0] w_grant;
  logic [W-1:0]     w_a, w_b, w_raw, w_sum;
  logic             w_ovf;
  logic             w_can;
  logic             w_acc;
  logic [IW-1:0]    w_ptr_nxt;

  // Round-robin search starting at r_ptr; first valid requester wins.
  always_comb begin
    w_any = 1'b0;
    w_gid = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_any && req_valid[(int'(r_ptr) + k) % N_REQ]) begin
        w_any = 1'b1;
        w_gid = IW'((int'(r_ptr) + k) % N_REQ);
      end
    end
    w_grant = w_any ? (N_REQ'(1) << w_gid) : '0;
  end

  // Shared saturating adder on the granted requester's operands.
  always_comb begin
    w_a   = req_a[int'(w_gid)*W +: W];
    w_b   = req_b[int'(w_gid)*W +: W];
    w_raw = w_a + w_b;
    w_ovf = (w_a[W-1] == w_b[W-1]) && (w_raw[W-1] != w_a[W-1]);
    if (w_ovf)
      w_sum = w_a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else
      w_sum = w_raw;
  end

  // Handshake: accept when the output slot is empty or draining this cycle.
  // req_ready is forced low during reset so nothing is seen as accepted.
  always_comb begin
    w_can     = !r_valid || out_ready;
    w_acc     = w_can && w_any;
    req_ready = (w_can && rst_n) ? w_grant : '0;
    w_ptr_nxt = (int'(w_gid) == N_REQ-1) ? '0 : IW'(int'(w_gid) + 1);
  end

  // Output register, pointer advance and drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_valid <= 1'b0;
      r_sum   <= '0;
      r_id    <= '0;
      r_sat   <= 1'b0;
    end else if (w_acc) begin
      r_valid <= 1'b1;
      r_sum   <= w_sum;
      r_id    <= w_gid;
      r_sat   <= w_ovf;
      r_ptr   <= w_ptr_nxt;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_sum   = r_sum;
  assign out_id    = r_id;
  assign out_sat   = r_sat;

`ifdef SAT_ADD_ARB_STICKY_EN
  logic [N_REQ-1:0] r_sticky;

  for (genvar i = 0; i < N_REQ; i++) begin : g_sticky
    // Per-requester sticky flag; a saturating accept beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        r_sticky[i] <= 1'b0;
      else if (w_acc && w_ovf && (int'(w_gid) == i))
        r_sticky[i] <= 1'b1;
      else if (sat_clr[i])
        r_sticky[i] <= 1'b0;
    end
  end

  assign sat_sticky = r_sticky;
`endif

endmodule

// File: tb/tb_sat_add_arbiter.sv
// Directed bench for sat_add_arbiter (N_REQ=4, W=4): a vector table for
// arithmetic and round-robin order, plus sequences for backpressure,
// asynchronous reset and, when compiled in, sticky saturation flags.
module tb_sat_add_arbiter;
  localparam int N = 4;
  localparam int W = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic [1:0]    out_id;
  logic          out_sat;
`ifdef SAT_ADD_ARB_STICKY_EN
  logic [N-1:0]  sat_clr;
  logic [N-1:0]  sat_sticky;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sat_add_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_id    (out_id),
    .out_sat   (out_sat)
`ifdef SAT_ADD_ARB_STICKY_EN
    ,
    .sat_clr   (sat_clr),
    .sat_sticky(sat_sticky)
`endif
  );

  typedef struct {
    logic [3:0]  vld;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  rdy;
    logic        ov;
    logic [3:0]  sum;
    logic [1:0]  id;
    logic        sat;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change just after the falling edge.
  task automatic drive(input logic [3:0] vld, input logic [15:0] a,
                       input logic [15:0] b, input logic ordy);
    @(negedge clk);
    req_valid = vld;
    req_a     = a;
    req_b     = b;
    out_ready = ordy;
    #1;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] sum,
                         input logic [1:0] id, input logic sat);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".out_sum"},   32'(out_sum),   32'(sum));
    chk({tag, ".out_id"},    32'(out_id),    32'(id));
    chk({tag, ".out_sat"},   32'(out_sat),   32'(sat));
  endtask

  initial begin
    // vld, a, b, ready-expected, out_valid, sum, id, sat
    vt[0]  = '{4'b0001, 16'h0003, 16'h0002, 4'b0001, 1'b1, 4'h5, 2'd0, 1'b0};
    vt[1]  = '{4'b0010, 16'h0070, 16'h0010, 4'b0010, 1'b1, 4'h7, 2'd1, 1'b1};
    vt[2]  = '{4'b0010, 16'h0080, 16'h00F0, 4'b0010, 1'b1, 4'h8, 2'd1, 1'b1};
    vt[3]  = '{4'b0010, 16'h0070, 16'h0080, 4'b0010, 1'b1, 4'hF, 2'd1, 1'b0};
    vt[4]  = '{4'b0010, 16'h00C0, 16'h00C0, 4'b0010, 1'b1, 4'h8, 2'd1, 1'b0};
    vt[5]  = '{4'b1000, 16'h4000, 16'h4000, 4'b1000, 1'b1, 4'h7, 2'd3, 1'b1};
    vt[6]  = '{4'b1111, 16'h3210, 16'h1111, 4'b0001, 1'b1, 4'h1, 2'd0, 1'b0};
    vt[7]  = '{4'b1111, 16'h3210, 16'h1111, 4'b0010, 1'b1, 4'h2, 2'd1, 1'b0};
    vt[8]  = '{4'b1111, 16'h3210, 16'h1111, 4'b0100, 1'b1, 4'h3, 2'd2, 1'b0};
    vt[9]  = '{4'b1111, 16'h3210, 16'h1111, 4'b1000, 1'b1, 4'h4, 2'd3, 1'b0};
    vt[10] = '{4'b1111, 16'h3210, 16'h1111, 4'b0001, 1'b1, 4'h1, 2'd0, 1'b0};
    vt[11] = '{4'b1111, 16'h3210, 16'h1111, 4'b0010, 1'b1, 4'h2, 2'd1, 1'b0};
    vt[12] = '{4'b0000, 16'h0000, 16'h0000, 4'b0000, 1'b0, 4'h0, 2'd0, 1'b0};

    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    out_ready = 1'b1;
`ifdef SAT_ADD_ARB_STICKY_EN
    sat_clr   = '0;
`endif
    #1;
    chk("rst.req_ready", 32'(req_ready), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_sum",   32'(out_sum),   32'd0);
    chk("rst.out_id",    32'(out_id),    32'd0);
    chk("rst.out_sat",   32'(out_sat),   32'd0);
`ifdef SAT_ADD_ARB_STICKY_EN
    chk("rst.sat_sticky", 32'(sat_sticky), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst.held_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;

    // Table: arithmetic corners and round-robin order.
    for (int i = 0; i < 13; i++) begin
      drive(vt[i].vld, vt[i].a, vt[i].b, 1'b1);
      chk($sformatf("v%0d.req_ready", i), 32'(req_ready), 32'(vt[i].rdy));
      edge_sample();
      chk($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(vt[i].ov));
      if (vt[i].ov) begin
        chk($sformatf("v%0d.out_sum", i), 32'(out_sum), 32'(vt[i].sum));
        chk($sformatf("v%0d.out_id", i),  32'(out_id),  32'(vt[i].id));
        chk($sformatf("v%0d.out_sat", i), 32'(out_sat), 32'(vt[i].sat));
      end
    end

    // Backpressure: slot empty so req2 (ptr=2) is taken even with out_ready low.
    drive(4'b1111, 16'h3210, 16'h1111, 1'b0);
    chk("bp.fill_ready", 32'(req_ready), 32'b0100);
    edge_sample();
    chk_out("bp.fill", 4'h3, 2'd2, 1'b0);
    for (int c = 0; c < 3; c++) begin
      drive(4'b1111, 16'h3210, 16'h1111, 1'b0);
      chk($sformatf("bp.hold%0d.ready", c), 32'(req_ready), 32'd0);
      edge_sample();
      chk_out($sformatf("bp.hold%0d", c), 4'h3, 2'd2, 1'b0);
    end
    drive(4'b1111, 16'h3210, 16'h1111, 1'b1);
    chk("bp.release_ready", 32'(req_ready), 32'b1000);
    edge_sample();
    chk_out("bp.refill", 4'h4, 2'd3, 1'b0);

    // Async reset with ptr=2 and a held result.
    drive(4'b0010, 16'h0010, 16'h0020, 1'b1);
    edge_sample();
    chk_out("ar.pre", 4'h3, 2'd1, 1'b0);
    req_valid = 4'b1001;
    req_a     = 16'h0000;
    req_b     = 16'h1001;
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar.out_valid", 32'(out_valid), 32'd0);
    chk("ar.req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ar.first_grant", 32'(req_ready), 32'b0001);
    edge_sample();
    chk_out("ar.post", 4'h1, 2'd0, 1'b0);

`ifdef SAT_ADD_ARB_STICKY_EN
    drive(4'b0100, 16'h0700, 16'h0100, 1'b1);
    edge_sample();
    chk_out("st.sat", 4'h7, 2'd2, 1'b1);
    chk("st.set", 32'(sat_sticky), 32'b0100);
    drive(4'b0100, 16'h0300, 16'h0100, 1'b1);
    edge_sample();
    chk_out("st.nosat", 4'h4, 2'd2, 1'b0);
    chk("st.keep", 32'(sat_sticky), 32'b0100);
    drive(4'b0100, 16'h0800, 16'h0F00, 1'b1);
    sat_clr = 4'b0100;
    edge_sample();
    chk("st.set_wins", 32'(sat_sticky), 32'b0100);
    drive(4'b0000, 16'h0000, 16'h0000, 1'b1);
    edge_sample();
    chk("st.clear", 32'(sat_sticky), 32'b0000);
    sat_clr = '0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/sat_add_arbiter.md
# sat_add_arbiter

Shares one W-bit signed saturating adder among N_REQ requesters. Round-robin arbitration picks at most one request per cycle. The saturated sum is registered into a one-entry output stage with valid/ready backpressure, tagged with the requester index and a saturation flag. It sits between independent arithmetic clients and the saturating add datapath so the adder is instantiated once.

## Interface
- N_REQ, 4: number of requesters, ≥2
- W, 4: operand/result width, two's complement, ≥2
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  request i presents operands
- req_ready  out  N_REQ  request i accepted this cycle (one-hot or zero)
- req_a  in  N_REQ*W  operand a of requester i at bits [i*W +: W]
- req_b  in  N_REQ*W  operand b of requester i at bits [i*W +: W]
- out_valid  out  1  result register holds a result
- out_ready  in  1  consumer accepts result
- out_sum  out  W  saturated sum
- out_id  out  $clog2(N_REQ)  index of originating requester
- out_sat  out  1  result was saturated

## Operation
- can_accept = !out_valid | out_ready.
- Round-robin pointer ptr starts at 0. Search requesters ptr, ptr+1, … mod N_REQ; the first with req_valid high is granted.
- req_ready[g] = can_accept & grant[g]; combinational from req_valid, ptr and out_*. All other bits are 0.
- On accept (req_valid[g] & req_ready[g]):
  - register sum, id = g, sat flag
  - out_valid ← 1
  - ptr ← (g+1) mod N_REQ
- No accept and out_valid & out_ready: out_valid ← 0. ptr unchanged.
- Requester rule: once req_valid is high, operands are held stable until ready. The block does not check this.
- Arithmetic: raw = a + b mod 2^W. Overflow = (a[W-1] == b[W-1]) & (raw[W-1] != a[W-1]).
  - Overflow with a positive: sum = 2^(W-1)-1.
  - Overflow with a negative: sum = -2^(W-1).
  - Otherwise sum = raw. out_sat = overflow.
- Mixed-sign operands never saturate.
- out_sum/out_id/out_sat are held stable while out_valid & !out_ready.
- Reset mid-operation discards any held result. No request is considered accepted in the reset cycle.

## Timing
- Reset values:
  - out_valid 0, out_sum 0, out_id 0, out_sat 0
  - ptr 0, req_ready 0 while rst_n low
  - sat_sticky 0 when compiled in
- Latency: accept at edge k gives out_valid high after edge k, i.e. 1 cycle.
- Throughput: 1 result/cycle while out_ready stays high. Same-cycle drain and refill is allowed.
- Fairness: a continuously valid requester is granted within N_REQ accepts.
- Single requester: granted every cycle that can_accept is high. ptr wraps from N_REQ-1 to 0.

## Configuration
- SAT_ADD_ARB_STICKY_EN defined:
  - Adds ports sat_clr (in, N_REQ) and sat_sticky (out, N_REQ).
  - sat_sticky[i] is set on the edge that accepts a saturating request from i.
  - It is cleared by sat_clr[i]. Set wins over a simultaneous clear.
  - Register output, reset 0.
- Not defined: both ports and the registers are absent. Behaviour is otherwise identical.

## Test plan
- Only req0 valid, a=3, b=2, out_ready=1 → out_valid next cycle, out_sum=5, out_id=0, out_sat=0.
- Saturation corners via req1:
  - 7+1 → 7, sat=1
  - (-8)+(-1) → 4'b1000, sat=1
  - 7+(-8) → 4'b1111, sat=0
  - (-4)+(-4) → 4'b1000, sat=0
- All four req_valid held high, out_ready=1 → out_id sequence 0,1,2,3,0,1 on consecutive cycles. Exactly one req_ready bit high each cycle.
- Result held, out_ready=0 for 3 cycles → out_* stable, req_ready=0. Raise out_ready → next request accepted in that same cycle and a new result appears on the following edge.
- rst_n pulsed low while out_valid=1 and ptr=2 → out_valid drops immediately, without waiting for clk. After release with req0 and req3 valid, req0 is granted first.
- With SAT_ADD_ARB_STICKY_EN: req2 saturates → sat_sticky[2]=1 and stays 1 for later non-saturating req2 results. Assert sat_clr[2] on the same edge as another req2 saturation → still 1. sat_clr[2] alone → 0.
